// File: rtl/std_cache_victim_sel.sv
// -----------------------------------------------------------------------------
// std_cache_victim_sel
//   Per-set dcache replacement unit. On a miss, the handler presents a set
//   index and that set's valid vector. One cycle later it receives a
//   registered one-hot victim way and its binary index. Hit and fill events
//   update the per-set replacement state.
//
//   POLICY 0 : one global 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hFF)
//   POLICY 1 : tree pseudo-LRU, SET_ASSOC-1 bits per set
//   POLICY 2 : per-set round-robin counter, advanced on fills only
//
//   An invalid way always wins over the policy choice (lowest index first).
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           asynchronous active-high reset
//   flush_i         synchronous clear of PLRU bits / RR counters (not the LFSR)
//   lookup_valid_i  victim request this cycle
//   lookup_idx_i    set index of the request
//   lookup_vld_i    valid bits of the addressed set
//   update_valid_i  replacement-state update strobe
//   update_idx_i    set index being updated
//   update_way_i    one-hot way accessed/filled (all-zero = no-op)
//   update_fill_i   1 = refill, 0 = hit
//   victim_valid_o  victim result valid (one cycle after the lookup)
//   victim_way_o    one-hot victim way (held while victim_valid_o = 0)
//   victim_bin_o    binary victim index (held while victim_valid_o = 0)
// -----------------------------------------------------------------------------

// Protocol checker: illegal update encodings, out-of-range indices, result shape.
module std_cache_victim_sel_chk #(
    parameter int unsigned NR_SETS   = 256,
    parameter int unsigned SET_ASSOC = 8,
    parameter int unsigned IDX_W     = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 lookup_valid_i,
    input logic [IDX_W-1:0]     lookup_idx_i,
    input logic                 update_valid_i,
    input logic [IDX_W-1:0]     update_idx_i,
    input logic [SET_ASSOC-1:0] update_way_i,
    input logic                 victim_valid_o,
    input logic [SET_ASSOC-1:0] victim_way_o
);

    update_way_onehot0_a: assert property (@(posedge clk_i) disable iff (rst_i)
        update_valid_i |-> $onehot0(update_way_i));

    lookup_idx_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        lookup_valid_i |-> (32'(lookup_idx_i) < 32'(NR_SETS)));

    update_idx_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        update_valid_i |-> (32'(update_idx_i) < 32'(NR_SETS)));

    victim_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
        victim_valid_o |-> $onehot(victim_way_o));

endmodule

module std_cache_victim_sel #(
    parameter int unsigned NR_SETS   = 256,
    parameter int unsigned SET_ASSOC = 8,
    parameter int unsigned POLICY    = 1,
    localparam int unsigned IDX_W    = (NR_SETS > 1) ? $clog2(NR_SETS) : 1,
    localparam int unsigned WAY_W    = $clog2(SET_ASSOC)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 lookup_valid_i,
    input  logic [IDX_W-1:0]     lookup_idx_i,
    input  logic [SET_ASSOC-1:0] lookup_vld_i,
    input  logic                 update_valid_i,
    input  logic [IDX_W-1:0]     update_idx_i,
    input  logic [SET_ASSOC-1:0] update_way_i,
    input  logic                 update_fill_i,
    output logic                 victim_valid_o,
    output logic [SET_ASSOC-1:0] victim_way_o,
    output logic [WAY_W-1:0]     victim_bin_o
);

    // Binary index of a one-hot (or all-zero) way vector.
    function automatic logic [WAY_W-1:0] onehot_to_bin(input logic [SET_ASSOC-1:0] oh);
        logic [WAY_W-1:0] b;
        b = '0;
        for (int i = 0; i < SET_ASSOC; i++) begin
            if (oh[i]) begin
                b = b | WAY_W'(i);
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    logic                 all_valid_s;
    logic [WAY_W-1:0]     free_bin_s;
    logic [WAY_W-1:0]     policy_bin_s;
    logic [WAY_W-1:0]     victim_bin_s;
    logic [WAY_W-1:0]     upd_bin_s;
    logic                 upd_any_s;

    logic                 victim_valid_r;
    logic [SET_ASSOC-1:0] victim_way_r;
    logic [WAY_W-1:0]     victim_bin_r;

    assign upd_bin_s = onehot_to_bin(update_way_i);
    assign upd_any_s = |update_way_i;

    // Lowest-index invalid way; scanning downwards lets the lowest index win.
    always_comb begin
        free_bin_s  = '0;
        all_valid_s = 1'b1;
        for (int i = SET_ASSOC - 1; i >= 0; i--) begin
            if (!lookup_vld_i[i]) begin
                free_bin_s  = WAY_W'(i);
                all_valid_s = 1'b0;
            end else begin
                free_bin_s  = free_bin_s;
            end
        end
    end

    generate
        if (POLICY == 0) begin : g_lfsr
            logic [7:0] lfsr_r;

            // Global LFSR, steps once per lookup regardless of hit/miss shape.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    lfsr_r <= 8'hFF;
                end else if (lookup_valid_i) begin
                    lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
                end
            end

            assign policy_bin_s = lfsr_r[WAY_W-1:0];
        end else if (POLICY == 1) begin : g_plru
            logic [SET_ASSOC-2:0] plru_r [NR_SETS];
            logic [SET_ASSOC-2:0] plru_rd_s;
            logic [SET_ASSOC-2:0] plru_wr_s;

            assign plru_rd_s = plru_r[lookup_idx_i];

            // Tree walk from the root: a 0 bit goes to the lower half.
            always_comb begin
                int   node_v;
                logic dir_v;
                policy_bin_s = '0;
                node_v       = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    dir_v                      = plru_rd_s[node_v];
                    policy_bin_s[WAY_W-1-l]    = dir_v;
                    node_v                     = 2 * node_v + 1 + int'(dir_v);
                end
            end

            // New tree for the updated set: every node on the path points away.
            always_comb begin
                int   node_v;
                logic wb_v;
                plru_wr_s = plru_r[update_idx_i];
                node_v    = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    wb_v              = upd_bin_s[WAY_W-1-l];
                    plru_wr_s[node_v] = ~wb_v;
                    node_v            = 2 * node_v + 1 + int'(wb_v);
                end
            end

            // PLRU storage; flush dominates a same-cycle update.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < NR_SETS; s++) begin
                        plru_r[s] <= '0;
                    end
                end else if (flush_i) begin
                    for (int s = 0; s < NR_SETS; s++) begin
                        plru_r[s] <= '0;
                    end
                end else if (update_valid_i && upd_any_s) begin
                    plru_r[update_idx_i] <= plru_wr_s;
                end
            end
        end else begin : g_rr
            logic [WAY_W-1:0] rr_r [NR_SETS];

            assign policy_bin_s = rr_r[lookup_idx_i];

            // Round-robin counters: next victim follows the way just filled.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < NR_SETS; s++) begin
                        rr_r[s] <= '0;
                    end
                end else if (flush_i) begin
                    for (int s = 0; s < NR_SETS; s++) begin
                        rr_r[s] <= '0;
                    end
                end else if (update_valid_i && update_fill_i && upd_any_s) begin
                    rr_r[update_idx_i] <= upd_bin_s + WAY_W'(1);
                end
            end
        end
    endgenerate

    assign victim_bin_s = all_valid_s ? policy_bin_s : free_bin_s;

    // Result register; way/bin hold while no lookup is presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            victim_valid_r <= 1'b0;
            victim_way_r   <= '0;
            victim_bin_r   <= '0;
        end else if (lookup_valid_i) begin
            victim_valid_r <= 1'b1;
            victim_way_r   <= SET_ASSOC'(1) << victim_bin_s;
            victim_bin_r   <= victim_bin_s;
        end else begin
            victim_valid_r <= 1'b0;
        end
    end

    assign victim_valid_o = victim_valid_r;
    assign victim_way_o   = victim_way_r;
    assign victim_bin_o   = victim_bin_r;

    std_cache_victim_sel_chk #(
        .NR_SETS   (NR_SETS),
        .SET_ASSOC (SET_ASSOC),
        .IDX_W     (IDX_W)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_idx_i   (lookup_idx_i),
        .update_valid_i (update_valid_i),
        .update_idx_i   (update_idx_i),
        .update_way_i   (update_way_i),
        .victim_valid_o (victim_valid_o),
        .victim_way_o   (victim_way_o)
    );

endmodule

// File: tb/tb_std_cache_victim_sel.sv
// -----------------------------------------------------------------------------
// tb_std_cache_victim_sel
//   Three instances (LFSR, PLRU, round-robin), 16 sets x 4 ways, sharing the
//   input buses. Directed vectors with hand-computed expectations; the LFSR
//   sequence is checked against a small reference model.
// -----------------------------------------------------------------------------
module tb_std_cache_victim_sel;

    localparam int unsigned NS = 16;
    localparam int unsigned NW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       lookup_valid = 1'b0;
    logic [3:0] lookup_idx = 4'd0;
    logic [3:0] lookup_vld = 4'd0;
    logic       update_valid = 1'b0;
    logic [3:0] update_idx = 4'd0;
    logic [3:0] update_way = 4'd0;
    logic       update_fill = 1'b0;

    logic       v0_valid, v1_valid, v2_valid;
    logic [3:0] v0_way, v1_way, v2_way;
    logic [1:0] v0_bin, v1_bin, v2_bin;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    std_cache_victim_sel #(.NR_SETS(NS), .SET_ASSOC(NW), .POLICY(0)) u_lfsr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_vld_i(lookup_vld),
        .update_valid_i(update_valid), .update_idx_i(update_idx), .update_way_i(update_way),
        .update_fill_i(update_fill),
        .victim_valid_o(v0_valid), .victim_way_o(v0_way), .victim_bin_o(v0_bin)
    );

    std_cache_victim_sel #(.NR_SETS(NS), .SET_ASSOC(NW), .POLICY(1)) u_plru (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_vld_i(lookup_vld),
        .update_valid_i(update_valid), .update_idx_i(update_idx), .update_way_i(update_way),
        .update_fill_i(update_fill),
        .victim_valid_o(v1_valid), .victim_way_o(v1_way), .victim_bin_o(v1_bin)
    );

    std_cache_victim_sel #(.NR_SETS(NS), .SET_ASSOC(NW), .POLICY(2)) u_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .lookup_valid_i(lookup_valid), .lookup_idx_i(lookup_idx), .lookup_vld_i(lookup_vld),
        .update_valid_i(update_valid), .update_idx_i(update_idx), .update_way_i(update_way),
        .update_fill_i(update_fill),
        .victim_valid_o(v2_valid), .victim_way_o(v2_way), .victim_bin_o(v2_bin)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [3:0] idx, input logic [3:0] vld);
        lookup_valid = 1'b1;
        lookup_idx   = idx;
        lookup_vld   = vld;
        step();
        lookup_valid = 1'b0;
    endtask

    task automatic do_update(input logic [3:0] idx, input logic [3:0] way, input logic fill);
        update_valid = 1'b1;
        update_idx   = idx;
        update_way   = way;
        update_fill  = fill;
        step();
        update_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        #2;
        rst = 1'b0;
        step();
    endtask

    logic [7:0] lfsr_m;

    initial begin
        // ---------------- reset state ----------------
        #1;
        check_vec("rst_valid_p0", 32'(v0_valid), 32'd0);
        check_vec("rst_valid_p1", 32'(v1_valid), 32'd0);
        check_vec("rst_valid_p2", 32'(v2_valid), 32'd0);
        check_vec("rst_way_p1",   32'(v1_way),   32'd0);
        check_vec("rst_bin_p2",   32'(v2_bin),   32'd0);
        step();
        #2;
        rst = 1'b0;
        step();

        // ---------------- PLRU first lookup ----------------
        do_lookup(4'd5, 4'b1111);
        check_vec("plru_first_valid", 32'(v1_valid), 32'd1);
        check_vec("plru_first_way",   32'(v1_way),   32'b0001);
        check_vec("plru_first_bin",   32'(v1_bin),   32'd0);
        step();
        check_vec("plru_valid_drop",  32'(v1_valid), 32'd0);
        check_vec("plru_way_hold",    32'(v1_way),   32'b0001);

        // ---------------- PLRU hits way0, way2 on set 5 ----------------
        do_update(4'd5, 4'b0001, 1'b0);
        do_update(4'd5, 4'b0100, 1'b0);
        do_lookup(4'd5, 4'b1111);
        check_vec("plru_s5_way", 32'(v1_way), 32'b0010);
        check_vec("plru_s5_bin", 32'(v1_bin), 32'd1);
        do_lookup(4'd6, 4'b1111);
        check_vec("plru_s6_way", 32'(v1_way), 32'b0001);
        check_vec("plru_s6_bin", 32'(v1_bin), 32'd0);

        // ---------------- invalid-way priority with same-cycle update ----------------
        update_valid = 1'b1;
        update_idx   = 4'd5;
        update_way   = 4'b0100;
        update_fill  = 1'b1;
        do_lookup(4'd5, 4'b1011);
        update_valid = 1'b0;
        check_vec("inv_way_p0", 32'(v0_way), 32'b0100);
        check_vec("inv_bin_p0", 32'(v0_bin), 32'd2);
        check_vec("inv_way_p1", 32'(v1_way), 32'b0100);
        check_vec("inv_bin_p1", 32'(v1_bin), 32'd2);
        check_vec("inv_way_p2", 32'(v2_way), 32'b0100);
        check_vec("inv_bin_p2", 32'(v2_bin), 32'd2);

        // ---------------- same-cycle lookup/update uses pre-update state ----------------
        update_valid = 1'b1;
        update_idx   = 4'd7;
        update_way   = 4'b0001;
        update_fill  = 1'b0;
        do_lookup(4'd7, 4'b1111);
        update_valid = 1'b0;
        check_vec("plru_pre_upd_bin",  32'(v1_bin), 32'd0);
        do_lookup(4'd7, 4'b1111);
        check_vec("plru_post_upd_bin", 32'(v1_bin), 32'd2);

        // ---------------- round-robin on set 3 ----------------
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_init_bin", 32'(v2_bin), 32'd0);
        do_update(4'd3, 4'b0001, 1'b1);
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_fill0_bin", 32'(v2_bin), 32'd1);
        do_update(4'd3, 4'b1000, 1'b1);
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_wrap_bin", 32'(v2_bin), 32'd0);
        check_vec("rr_wrap_way", 32'(v2_way), 32'b0001);
        do_update(4'd3, 4'b0010, 1'b0);
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_hit_bin", 32'(v2_bin), 32'd0);
        do_update(4'd3, 4'b0010, 1'b1);
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_fill1_bin", 32'(v2_bin), 32'd2);
        do_update(4'd3, 4'b0000, 1'b1);
        do_lookup(4'd3, 4'b1111);
        check_vec("rr_zero_upd_bin", 32'(v2_bin), 32'd2);

        // ---------------- LFSR: back-to-back lookups, two full periods ----------------
        do_reset();
        lfsr_m       = 8'hFF;
        lookup_valid = 1'b1;
        lookup_idx   = 4'd0;
        lookup_vld   = 4'b1111;
        for (int i = 0; i < 510; i++) begin
            step();
            if (i == 0) begin
                check_vec("lfsr_first",  32'(v0_bin), 32'd3);
            end
            if (i == 1) begin
                check_vec("lfsr_second", 32'(v0_bin), 32'd2);
            end
            check_vec("lfsr_seq", 32'(v0_bin), 32'(lfsr_m[1:0]));
            check_vec("lfsr_valid", 32'(v0_valid), 32'd1);
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
        lookup_valid = 1'b0;
        step();

        // ---------------- flush overrides update; LFSR untouched ----------------
        do_reset();
        do_update(4'd5, 4'b0001, 1'b1);
        flush        = 1'b1;
        update_valid = 1'b1;
        update_idx   = 4'd5;
        update_way   = 4'b0100;
        update_fill  = 1'b1;
        do_lookup(4'd5, 4'b1111);
        flush        = 1'b0;
        update_valid = 1'b0;
        check_vec("flush_cyc_plru_bin", 32'(v1_bin), 32'd2);
        check_vec("flush_cyc_rr_bin",   32'(v2_bin), 32'd1);
        check_vec("flush_cyc_lfsr_bin", 32'(v0_bin), 32'd3);
        do_lookup(4'd5, 4'b1111);
        check_vec("post_flush_plru_bin", 32'(v1_bin), 32'd0);
        check_vec("post_flush_rr_bin",   32'(v2_bin), 32'd0);
        check_vec("post_flush_lfsr_bin", 32'(v0_bin), 32'd2);

        // ---------------- async reset drops pending result ----------------
        do_lookup(4'd5, 4'b1111);
        check_vec("pre_rst_valid", 32'(v1_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_vec("async_rst_valid_p0", 32'(v0_valid), 32'd0);
        check_vec("async_rst_valid_p1", 32'(v1_valid), 32'd0);
        check_vec("async_rst_valid_p2", 32'(v2_valid), 32'd0);
        check_vec("async_rst_way_p1",   32'(v1_way),   32'd0);
        step();
        #2;
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/std_cache_victim_sel.md
Name: std_cache_victim_sel

Overview:
- Parametrised dcache replacement unit. It generalises the combinational "first valid/dirty way" victim pick into a stateful, per-set selector with a selectable policy.
- It sits beside the std_cache tag/state arrays.
- On a miss, the miss handler presents the set index and that set's valid vector, and receives a registered one-hot victim way plus its binary index.
- Hit and fill events update per-set replacement state.

Parameters:
- NR_SETS, 256, number of sets; index width IDX_W = $clog2(NR_SETS).
- SET_ASSOC, 8, ways per set; power of two, >= 2; WAY_W = $clog2(SET_ASSOC).
- POLICY, 1, replacement mode: 0 = LFSR pseudo-random, 1 = tree pseudo-LRU, 2 = per-set round-robin.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear of all replacement state.
- lookup_valid_i  in  1  victim request this cycle.
- lookup_idx_i  in  IDX_W  set index of the request.
- lookup_vld_i  in  SET_ASSOC  valid bits of the addressed set.
- update_valid_i  in  1  replacement-state update strobe.
- update_idx_i  in  IDX_W  set index being updated.
- update_way_i  in  SET_ASSOC  one-hot way being accessed or filled.
- update_fill_i  in  1  1 = refill, 0 = hit.
- victim_valid_o  out  1  victim result valid.
- victim_way_o  out  SET_ASSOC  one-hot victim way.
- victim_bin_o  out  WAY_W  binary victim index.

Behaviour:
- Reset (rst_i=1, async):
  - victim_valid_o=0, victim_way_o=0, victim_bin_o=0.
  - All PLRU bits = 0.
  - All RR counters = 0.
  - LFSR = 8'hFF.
- Latency:
  - Outputs are registered; a lookup in cycle N produces victim_valid_o=1 in cycle N+1 only.
  - No backpressure; a new lookup may be issued every cycle.
  - victim_way_o/victim_bin_o hold their last value while victim_valid_o=0.
- Invalid-way priority (all policies):
  - If lookup_vld_i is not all ones, the victim is the lowest-index way with lookup_vld_i[i]=0.
  - Replacement state is not consulted.
  - The LFSR still advances on that lookup.
- POLICY 0:
  - One global 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hFF.
  - Victim = lfsr[WAY_W-1:0] for a lookup with all ways valid.
  - The LFSR advances once per cycle with lookup_valid_i=1.
  - Updates are ignored.
- POLICY 1: tree PLRU with SET_ASSOC-1 bits per set.
  - Node 0 is the root; node n has children 2n+1 (lower half) and 2n+2 (upper half).
  - Victim walk: bit=0 selects the lower half, bit=1 the upper half.
  - An update to way w sets every node on w's path to point away from w. Hits and fills are treated identically.
- POLICY 2: per-set WAY_W-bit counter.
  - Victim = counter value.
  - On update with update_fill_i=1, counter <= bin(update_way_i)+1, wrapping modulo SET_ASSOC.
  - Hits are ignored.
- update_way_i handling:
  - All-zero: the update is a no-op.
  - Multi-hot is illegal and must be covered by an assertion.
- Same-set lookup and update in one cycle: the lookup uses the pre-update state; the update is visible to lookups from the next cycle.
- flush_i:
  - Clears all PLRU bits and RR counters at the next edge and overrides any same-cycle update.
  - The LFSR is not flushed.
  - A same-cycle lookup still completes, using pre-flush state.
- Async reset mid-operation drops any pending result: victim_valid_o=0 immediately.
- Out-of-range index (NR_SETS not a power of two) is illegal; covered by an assertion.
- Storage is flops or latch-free registers; read and update are single-cycle.

Test Plan:
- POLICY=1, SET_ASSOC=4, reset; lookup set 5, lookup_vld_i=4'b1111 -> next cycle victim_valid_o=1, victim_way_o=4'b0001, victim_bin_o=0.
- POLICY=1, SET_ASSOC=4; hit way0 then hit way2 on set 5; lookup set 5 all valid -> victim_way_o=4'b0010 (bin 1); lookup set 6 -> 4'b0001 (bin 0).
- Any policy; lookup with lookup_vld_i=4'b1011 -> victim_way_o=4'b0100, bin 2, regardless of state. A same-cycle update to the same set does not change this result.
- POLICY=2, SET_ASSOC=4, set 3:
  - Lookup -> bin 0.
  - Fill way0; lookup -> bin 1.
  - Fill way3; lookup -> bin 0 (wrap).
  - Hit way1; lookup -> bin 0 (unchanged).
- POLICY=0, SET_ASSOC=4, reset; first all-valid lookup -> bin 3 (lfsr 8'hFF). The second lookup result matches a reference LFSR model; 255 consecutive lookups repeat with period 255.
- POLICY=1; hit way0 on set 5, then flush_i=1 together with an update to way2 -> lookup set 5 returns bin 0; assert rst_i while victim_valid_o=1 -> victim_valid_o=0 in the same cycle.
